// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with scalable active window
// Pixel/line counters plus a one-cycle-latency registered decode of sync, blank and window outputs.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk25,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic          hsync,
  output logic          vsync,
  output logic          nblank,
  output logic          nsync,
  output logic          active_area,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_start,
  output logic          clkout
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_cw_check
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_START   = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END     = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START   = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END     = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_DISPLAY);
  localparam logic [CW-1:0] H_VIS_HALF = CW'(H_DISPLAY / 2);
  localparam logic [CW-1:0] H_VIS_QTR  = CW'(H_DISPLAY / 4);
  localparam logic [CW-1:0] V_VIS      = CW'(V_DISPLAY);
  localparam logic [CW-1:0] V_VIS_HALF = CW'(V_DISPLAY / 2);
  localparam logic [CW-1:0] V_VIS_QTR  = CW'(V_DISPLAY / 4);

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic [1:0]    r_mode_q;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_nblank;
  logic          r_active;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_frame_start;
  logic          r_line_start;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_in_hs;
  logic          w_in_vs;
  logic          w_in_display;
  logic          w_in_window;
  logic [CW-1:0] w_h_lim;
  logic [CW-1:0] w_v_lim;

  assign w_h_last     = (r_hcnt == H_LAST);
  assign w_v_last     = (r_vcnt == V_LAST);
  assign w_in_hs      = (r_hcnt >= HS_START) && (r_hcnt <= HS_END);
  assign w_in_vs      = (r_vcnt >= VS_START) && (r_vcnt <= VS_END);
  assign w_in_display = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
  assign w_in_window  = (r_hcnt < w_h_lim) && (r_vcnt < w_v_lim);

  // mode 3 is an unused encoding and falls back to the full window
  always_comb begin
    w_h_lim = H_VIS;
    w_v_lim = V_VIS;
    case (r_mode_q)
      2'd1: begin
        w_h_lim = H_VIS_HALF;
        w_v_lim = V_VIS_HALF;
      end
      2'd2: begin
        w_h_lim = H_VIS_QTR;
        w_v_lim = V_VIS_QTR;
      end
      default: begin
        w_h_lim = H_VIS;
        w_v_lim = V_VIS;
      end
    endcase
  end

  // Window size is sampled only on the last pixel of a frame so a frame never changes shape mid-scan
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_mode_q <= 2'd0;
    end else if (en) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        if (w_v_last) begin
          r_vcnt   <= '0;
          r_mode_q <= mode;
        end else begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_nblank      <= 1'b0;
      r_active      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (en) begin
      r_hsync       <= w_in_hs ? HS_POL : ~HS_POL;
      r_vsync       <= w_in_vs ? VS_POL : ~VS_POL;
      r_nblank      <= w_in_display;
      r_active      <= w_in_window;
      r_x           <= w_in_window ? r_hcnt : '0;
      r_y           <= w_in_window ? r_vcnt : '0;
      r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
      r_line_start  <= (r_hcnt == '0) && (r_vcnt < V_VIS);
    end else begin
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign nblank      = r_nblank;
  assign nsync       = 1'b1;
  assign active_area = r_active;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign clkout      = clk25;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, 0, active level of hsync.
REQ-010 Parameter VS_POL, 0, active level of vsync.
REQ-011 Parameter CW, 10, width of the counters and of x/y.
REQ-012 clk25  in  1  pixel clock.
REQ-013 rst  in  1  reset, asynchronous, active-low.
REQ-014 en  in  1  pixel enable; counters advance only when high.
REQ-015 mode  in  2  active window: 0 full, 1 half (H/2 x V/2), 2 quarter (H/4 x V/4), 3 treated as 0.
REQ-016 hsync, vsync  out  1 each  sync outputs, polarity per HS_POL/VS_POL.
REQ-017 nblank  out  1  high inside the full H_DISPLAY x V_DISPLAY area.
REQ-018 nsync  out  1  tied high.
REQ-019 active_area  out  1  high inside the scaled window.
REQ-020 x, y  out  CW each  pixel coordinates inside the scaled window, 0 outside.
REQ-021 frame_start, line_start  out  1 each  single-cycle pulses.
REQ-022 clkout  out  1  clk25 forwarded combinationally.

Function
REQ-023 H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters.
REQ-024 Elaboration shall fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1.
REQ-025 hcnt shall run 0..H_TOTAL-1 and wrap to 0.
REQ-026 vcnt shall increment on each hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-027 Counters shall hold when en=0.
REQ-028 All outputs except nsync/clkout shall be registered and mutually aligned.
REQ-029 Outputs shall update only on en=1 cycles, decoding the pre-increment counter value (one-cycle latency).
REQ-030 hsync = HS_POL when hcnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], else ~HS_POL.
REQ-031 vsync = VS_POL when vcnt is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], else ~VS_POL.
REQ-032 nblank = (hcnt < H_DISPLAY) and (vcnt < V_DISPLAY).
REQ-033 active_area = (hcnt < H_DISPLAY>>s) and (vcnt < V_DISPLAY>>s), with s = mode_q (0/1/2).
REQ-034 x = hcnt and y = vcnt while active_area, else both 0.
REQ-035 frame_start = 1 for the decode of hcnt=0, vcnt=0.
REQ-036 line_start = 1 for the decode of hcnt=0 with vcnt < V_DISPLAY.
REQ-037 When en=0, frame_start and line_start shall be 0; all other outputs hold.
REQ-038 mode_q shall load from mode only on the en cycle where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
REQ-039 A mode change mid-frame shall take effect from the next frame only.

Reset
REQ-040 rst=0 shall immediately clear hcnt, vcnt, mode_q, active_area, x, y, nblank, frame_start and line_start to 0, and drive hsync=~HS_POL and vsync=~VS_POL.
REQ-041 After reset the first frame shall be full window (mode_q=0), regardless of mode.
REQ-042 On the first en=1 cycle after rst release, frame_start=1 and line_start=1.
REQ-043 Assertion of rst mid-line or mid-frame shall abort the frame with no residual pulse.

Verification
REQ-044 Defaults, mode=0, en=1: hsync low for 96 cycles starting at decoded hcnt=656; line period 800 cycles; frame period 420000 cycles.
REQ-045 vsync low for exactly 1600 cycles starting at line 490; nblank high for 307200 cycles per frame.
REQ-046 mode=2 held from reset: second frame has active_area high for 19200 cycles, x 0..159 and y 0..119, and first frame has 307200.
REQ-047 mode 0->1 changed at line 100: current frame gives 307200 active cycles, next frame gives 76800; mode=3 gives 307200.
REQ-048 en low for 10 cycles at hcnt=300: all outputs frozen, no pulses, line length 810 clocks.
REQ-049 rst pulsed at hcnt=500, vcnt=200: outputs reach reset values asynchronously; first en cycle after release gives frame_start=1; HS_POL=1 build gives hsync high only for the 96 sync cycles.
